// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared constants, repeat FSM states and counter sizing for the input conditioner bank
package input_cond_pkg;
  localparam int DEF_TICK_DIV = 100000;
  localparam int DEF_DB_TICKS = 10;
  localparam int DEF_RPT_DELAY_TICKS = 500;
  localparam int DEF_RPT_PERIOD_TICKS = 100;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one input channel - synchroniser, tick-based debounce, edge pulses and optional hold-to-repeat
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DB_TICKS = DEF_DB_TICKS,
  parameter int RPT_DELAY_TICKS = DEF_RPT_DELAY_TICKS,
  parameter int RPT_PERIOD_TICKS = DEF_RPT_PERIOD_TICKS,
  parameter bit RPT_EN = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press
);
  localparam int DW = cnt_w(DB_TICKS);
  logic [1:0] sync_q;
  logic [DW-1:0] dbc;
  logic mismatch, flip, rise_n, fall_n;
  assign mismatch = sync_q[1] ^ level;
  assign flip = mismatch && tick && (dbc == DW'(DB_TICKS - 1));
  assign rise_n = flip && !level;
  assign fall_n = flip && level;
  // two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '0;
    else sync_q <= {sync_q[0], raw};
  // count consecutive mismatching ticks; any matching cycle restarts the count
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dbc <= '0;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      dbc <= (!mismatch || flip) ? '0 : tick ? dbc + 1'b1 : dbc;
      level <= level ^ flip;
      rise <= rise_n;
      fall <= fall_n;
    end
  generate
    if (RPT_EN) begin : g_rpt
      localparam int RW = cnt_w((RPT_DELAY_TICKS > RPT_PERIOD_TICKS) ? RPT_DELAY_TICKS : RPT_PERIOD_TICKS);
      rpt_state_e state;
      logic [RW-1:0] rc;
      logic rpt;
      assign rpt = tick && ((state == DELAY && rc == RW'(RPT_DELAY_TICKS - 1)) ||
                            (state == REPEAT && rc == RW'(RPT_PERIOD_TICKS - 1)));
      // hold-to-repeat: initial delay, then periodic presses; a fall always wins and cancels the pulse
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          state <= IDLE;
          rc <= '0;
          press <= 1'b0;
        end else begin
          press <= rise_n || (rpt && !fall_n);
          if (fall_n) begin
            state <= IDLE;
            rc <= '0;
          end else if (rise_n) begin
            state <= DELAY;
            rc <= '0;
          end else if (rpt) begin
            state <= REPEAT;
            rc <= '0;
          end else if (tick && state != IDLE) rc <= rc + 1'b1;
        end
    end else begin : g_norpt
      assign press = rise;
    end
  endgenerate
endmodule

// File: rtl/input_conditioner_bank.sv
// input_conditioner_bank: N_CH independent debounced inputs sharing one sample-tick prescaler
module input_conditioner_bank
  import input_cond_pkg::*;
#(
  parameter int N_CH = 9,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int DB_TICKS = DEF_DB_TICKS,
  parameter int RPT_DELAY_TICKS = DEF_RPT_DELAY_TICKS,
  parameter int RPT_PERIOD_TICKS = DEF_RPT_PERIOD_TICKS,
  parameter logic [N_CH-1:0] RPT_MASK = 9'b0_0000_1111
) (
  input  logic clk,
  input  logic reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] press
);
  localparam int PW = cnt_w(TICK_DIV - 1);
  logic [PW-1:0] pcnt;
  logic tick;
  assign tick = pcnt == PW'(TICK_DIV - 1);
  // free-running prescaler; tick marks the last count of each period
  always_ff @(posedge clk or posedge reset)
    if (reset) pcnt <= '0;
    else pcnt <= tick ? '0 : pcnt + 1'b1;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DB_TICKS(DB_TICKS),
      .RPT_DELAY_TICKS(RPT_DELAY_TICKS),
      .RPT_PERIOD_TICKS(RPT_PERIOD_TICKS),
      .RPT_EN(RPT_MASK[i])
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .raw(raw_in[i]),
      .tick(tick),
      .level(level[i]),
      .rise(rise[i]),
      .fall(fall[i]),
      .press(press[i])
    );
  end
endmodule

// File: tb/tb_input_conditioner_bank.sv
// tb_input_conditioner_bank: directed checks of debounce latency, glitch rejection, repeat timing and reset
module tb_input_conditioner_bank;
  localparam int N = 9;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] level, rise, fall, press;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise_cnt[N];
  int fall_cnt[N];
  int press_cnt[N];
  int coinc_err = 0;
  int rise_cyc1 = 0;
  int press_log[$];
  int n, bad, after_fall;

  always #5 clk = ~clk;

  input_conditioner_bank #(
    .N_CH(9),
    .TICK_DIV(4),
    .DB_TICKS(3),
    .RPT_DELAY_TICKS(5),
    .RPT_PERIOD_TICKS(2),
    .RPT_MASK(9'b0_0000_1111)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
    .level(level),
    .rise(rise),
    .fall(fall),
    .press(press)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] += int'(rise[i] === 1'b1);
      fall_cnt[i] += int'(fall[i] === 1'b1);
      press_cnt[i] += int'(press[i] === 1'b1);
    end
    if (press[1] === 1'b1) press_log.push_back(cyc);
    if (rise[1] === 1'b1) rise_cyc1 = cyc;
    coinc_err += $countones((press ^ rise) & 9'h1f0);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
      press_cnt[i] = 0;
    end
  endtask

  task automatic wait_level(input string tag, input int ch, input logic val, input int maxc, output int cnt);
    cnt = 0;
    while (level[ch] !== val && cnt < maxc) begin
      step();
      cnt++;
    end
    check(tag, level[ch], val);
  endtask

  initial begin
    repeat (3) step();
    check("rst_level", level, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_press", press, 0);
    reset = 1'b0;
    clear_counts();

    raw_in[0] = 1'b1;
    wait_level("s1_level_up", 0, 1'b1, 30, n);
    check("s1_latency_window", n >= 11 && n <= 14, 1);
    check("s1_rise", rise[0], 1);
    check("s1_press", press[0], 1);
    check("s1_only_ch0", level, 9'h001);
    step();
    check("s1_rise_one_cycle", rise[0], 0);
    raw_in[0] = 1'b0;
    wait_level("s1_level_down", 0, 1'b0, 30, n);
    check("s1_fall", fall[0], 1);
    check("s1_press_cnt", press_cnt[0], 1);
    check("s1_rise_cnt", rise_cnt[0], 1);

    clear_counts();
    for (int k = 0; k < 40; k++) begin
      raw_in[5] = ((k / 3) % 2) == 0;
      step();
    end
    check("s2_no_rise_bounce", rise_cnt[5], 0);
    check("s2_level_bounce", level[5], 0);
    raw_in[5] = 1'b1;
    wait_level("s2_level_up", 5, 1'b1, 30, n);
    check("s2_rise_cnt", rise_cnt[5], 1);
    raw_in[5] = 1'b0;
    wait_level("s2_level_down", 5, 1'b0, 30, n);

    clear_counts();
    press_log.delete();
    raw_in[1] = 1'b1;
    repeat (200) step();
    check("s3_first_at_rise", press_log[0], rise_cyc1);
    check("s3_delay_gap", press_log[1] - press_log[0], 20);
    bad = 0;
    for (int k = 2; k < press_log.size(); k++)
      if (press_log[k] - press_log[k-1] != 8) bad++;
    check("s3_period_gaps", bad, 0);
    check("s3_count_window", press_log.size() >= 22 && press_log.size() <= 23, 1);
    raw_in[1] = 1'b0;
    wait_level("s3_level_down", 1, 1'b0, 30, n);
    check("s3_fall", fall[1], 1);
    check("s3_no_press_at_fall", press[1], 0);
    after_fall = press_log.size();
    repeat (40) step();
    check("s3_no_press_after_fall", press_log.size(), after_fall);

    clear_counts();
    raw_in[6] = 1'b1;
    repeat (200) step();
    check("s4_press_cnt", press_cnt[6], 1);
    check("s4_rise_cnt", rise_cnt[6], 1);
    raw_in[6] = 1'b0;
    wait_level("s4_level_down", 6, 1'b0, 30, n);

    raw_in[2] = 1'b1;
    raw_in[7] = 1'b1;
    wait_level("s5_level_up", 2, 1'b1, 30, n);
    check("s5_rise2", rise[2], 1);
    check("s5_rise7", rise[7], 1);
    raw_in[2] = 1'b0;
    raw_in[7] = 1'b0;
    wait_level("s5_level_down", 2, 1'b0, 30, n);
    check("s5_fall7", fall[7], 1);

    raw_in[0] = 1'b1;
    wait_level("s6_level_up", 0, 1'b1, 30, n);
    repeat (30) step();
    reset = 1'b1;
    #1;
    check("s6_async_clear", {level, rise, fall, press}, 0);
    repeat (3) step();
    clear_counts();
    reset = 1'b0;
    wait_level("s6_level_up_again", 0, 1'b1, 30, n);
    check("s6_latency", n, 12);
    check("s6_rise", rise[0], 1);
    check("s6_press_cnt", press_cnt[0], 1);
    raw_in[0] = 1'b0;
    wait_level("s6_level_down", 0, 1'b0, 30, n);

    check("unmasked_press_eq_rise", coinc_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/input_conditioner_bank.md
# input_conditioner_bank

Parametrised successor to the team's fixed 4-switch/5-button debounce bank: synchronises, debounces and edge-detects `N_CH` raw board inputs and adds per-channel hold-to-repeat for navigation buttons. It sits between the board pins and the RTC/VGA controllers, replacing the old bank in the top level. All channel timing derives from one shared prescaler tick, which keeps per-channel counters narrow.

## Interface
- `N_CH`, 9: number of input channels.
- `TICK_DIV`, 100000: clock cycles per sample tick (1 ms at 100 MHz).
- `DB_TICKS`, 10: consecutive mismatching ticks needed to accept a new level.
- `RPT_DELAY_TICKS`, 500: ticks held high before the first repeat pulse.
- `RPT_PERIOD_TICKS`, 100: ticks between subsequent repeat pulses.
- `RPT_MASK`, 9'b0_0000_1111: channels with auto-repeat enabled (bit i = channel i).
- `clk`  in  1  system clock; the single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `raw_in`  in  N_CH  asynchronous switch/button levels.
- `level`  out  N_CH  debounced level.
- `rise`  out  N_CH  one-cycle pulse when `level` goes 0→1.
- `fall`  out  N_CH  one-cycle pulse when `level` goes 1→0.
- `press`  out  N_CH  `rise` OR repeat pulses (repeat only where `RPT_MASK` is set).

## Operation
- Synchroniser: 2 flops per channel; `sync[i]` is `raw_in[i]` delayed 2 cycles.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when the count equals TICK_DIV-1.
- Per-channel debounce counter `dbc`, width clog2(DB_TICKS+1):
  - `sync == level`: `dbc` clears on any cycle, tick or not.
  - `sync != level` and `tick`: `dbc` increments.
  - `dbc == DB_TICKS-1` and `tick` and mismatch: `level` toggles, `dbc` clears, and `rise` or `fall` pulses in the same cycle `level` changes.
- Repeat FSM per masked channel:
  - IDLE: on `rise`, go to DELAY with `rc`=0.
  - DELAY: count ticks; when `rc` == RPT_DELAY_TICKS-1 on a tick, pulse `press`, clear `rc`, go to REPEAT.
  - REPEAT: when `rc` == RPT_PERIOD_TICKS-1 on a tick, pulse `press` and clear `rc`.
  - From any state, `fall` returns the FSM to IDLE with `rc`=0, with no pulse in that cycle.
- Unmasked channels: `press` == `rise`; the FSM is absent or tied off.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.

## Timing
- Reset (async assert, sync-free deassert acceptable): all outputs, synchronisers, prescaler, `dbc`, `rc` go to 0 and FSMs to IDLE. `level` resets to 0, so inputs held high at reset release produce a `rise` after the debounce time.
- Latency from a `raw_in` step to the `level` change: 2 cycles + between (DB_TICKS-1)·TICK_DIV+1 and DB_TICKS·TICK_DIV cycles.
- Glitch rejection: a mismatch lasting fewer than DB_TICKS consecutive ticks never changes `level`. Any single matching cycle restarts the count.
- Every pulse is exactly one `clk` cycle. `press` never pulses twice in one cycle.
- Reset mid-debounce or mid-repeat: the count is discarded and no pulse is emitted after release until the full debounce time elapses again.
- Counter widths: clog2(max+1). No overflow is possible because counters clear at their terminal values.

## Structure
- Package `input_cond_pkg`:
  - default constants (tick/debounce/repeat values for 100 MHz);
  - FSM state enum (IDLE, DELAY, REPEAT);
  - a width function for counter sizing.
- Sub-module `debounce_channel` (synchroniser, `dbc`, edge pulses, repeat FSM, per-channel repeat-enable parameter), instantiated `N_CH` times in a generate loop.
- The top instantiates the shared prescaler.

## Test plan
All scenarios use TICK_DIV=4, DB_TICKS=3, RPT_DELAY_TICKS=5, RPT_PERIOD_TICKS=2, N_CH=9.
- Clean press: `raw_in[0]` 0→1 and held → `level[0]`=1 and one-cycle `rise[0]`/`press[0]` within 11–14 cycles; no other channel toggles.
- Bounce: `raw_in[5]` toggles every 3 cycles for 40 cycles, then holds 1 → exactly one `rise[5]`, and only after the hold.
- Hold-repeat on masked ch1: held 200 cycles → `press[1]` at `rise`, again 20 cycles later, then every 8 cycles. On release, `fall[1]` fires and no further `press`.
- Unmasked ch6 held 200 cycles → exactly one `press[6]`, coincident with `rise[6]`.
- Simultaneous edges on ch2 and ch7 in the same cycle → `rise[2]` and `rise[7]` in the same cycle.
- `reset` asserted mid-repeat on ch0 → all outputs 0 immediately. With `raw_in[0]` still high after release, `rise[0]` fires again after full debounce.
